// File: rtl/riscv_dmem_arbiter_if.sv
// Signal bundle joining two data-memory requesters, the arbiter and the data memory.
// The slave view is the arbiter's; the master view is the requesters' and memory's.
interface riscv_dmem_arbiter_if;
  logic [1:0]   req_val;
  logic [1:0]   req_rdy;
  logic [7:0]   req_op;
  logic [63:0]  req_addr;
  logic [127:0] req_data;
  logic [15:0]  req_wmask;
  logic [23:0]  req_tag;

  logic         mem_req_val;
  logic         mem_req_rdy;
  logic [3:0]   mem_req_op;
  logic [31:0]  mem_req_addr;
  logic [63:0]  mem_req_data;
  logic [7:0]   mem_req_wmask;
  logic [12:0]  mem_req_tag;

  logic         mem_resp_val;
  logic [12:0]  mem_resp_tag;
  logic [63:0]  mem_resp_data;

  logic [1:0]   resp_val;
  logic [11:0]  resp_tag;
  logic [63:0]  resp_data;

  modport slave (
    input  req_val, req_op, req_addr, req_data, req_wmask, req_tag,
    input  mem_req_rdy, mem_resp_val, mem_resp_tag, mem_resp_data,
    output req_rdy, mem_req_val, mem_req_op, mem_req_addr, mem_req_data,
    output mem_req_wmask, mem_req_tag, resp_val, resp_tag, resp_data
  );

  modport master (
    output req_val, req_op, req_addr, req_data, req_wmask, req_tag,
    output mem_req_rdy, mem_resp_val, mem_resp_tag, mem_resp_data,
    input  req_rdy, mem_req_val, mem_req_op, mem_req_addr, mem_req_data,
    input  mem_req_wmask, mem_req_tag, resp_val, resp_tag, resp_data
  );
endinterface

// File: rtl/riscv_dmem_arbiter.sv
// Two-requester round-robin data-memory arbiter with per-requester outstanding
// limits, a held grant under backpressure and a drain-before-flush sequence.
module riscv_dmem_arbiter #(
  parameter int MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_dmem_arbiter_if.slave  bus
);
  localparam logic [3:0] M_FLA    = 4'b0100;
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]  r_state;
  logic        r_ptr;
  logic        r_owner;
  logic        r_owner_go;
  logic        r_lock_val;
  logic        r_lock_idx;
  logic [3:0]  r_lock_op;
  logic [31:0] r_lock_addr;
  logic [63:0] r_lock_data;
  logic [7:0]  r_lock_wmask;
  logic [11:0] r_lock_tag;

  logic [3:0]  w_cnt [2];
  logic [1:0]  w_elig;
  logic [1:0]  w_is_fla;
  logic [4:0]  w_total;
  logic        w_total_zero;
  logic        w_top_idx;
  logic        w_drain_start;
  logic        w_has_win;
  logic        w_win;
  logic        w_hs;

  logic [3:0]  w_sel_op;
  logic [31:0] w_sel_addr;
  logic [63:0] w_sel_data;
  logic [7:0]  w_sel_wmask;
  logic [11:0] w_sel_tag;

  assign w_total      = {1'b0, w_cnt[0]} + {1'b0, w_cnt[1]};
  assign w_total_zero = (w_total == 5'd0);
  assign w_hs         = w_has_win && bus.mem_req_rdy;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic [3:0] r_cnt;
      logic       w_inc;
      logic       w_dec;

      assign w_is_fla[gi] = (bus.req_op[gi*4 +: 4] == M_FLA);
      assign w_elig[gi]   = bus.req_val[gi] && (r_cnt < 4'(MAX_OUT)) &&
                            (!w_is_fla[gi] || w_total_zero);
      assign w_inc        = w_hs && (w_win == 1'(gi));
      // Responses for requests lost across a reset must not underflow the count.
      assign w_dec        = bus.mem_resp_val && (bus.mem_resp_tag[12] == 1'(gi)) &&
                            (r_cnt != 4'd0);
      assign w_cnt[gi]    = r_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= 4'd0;
        end else if (w_inc && !w_dec) begin
          r_cnt <= r_cnt + 4'd1;
        end else if (w_dec && !w_inc) begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  endgenerate

  always_comb begin
    w_top_idx     = bus.req_val[r_ptr] ? r_ptr : ~r_ptr;
    w_drain_start = 1'b0;
    w_has_win     = 1'b0;
    w_win         = r_ptr;
    if (r_lock_val) begin
      w_has_win = 1'b1;
      w_win     = r_lock_idx;
    end else if (r_state == ST_ARB) begin
      if (r_owner_go) begin
        w_has_win = 1'b1;
        w_win     = r_owner;
      end else if ((|bus.req_val) && w_is_fla[w_top_idx] && !w_total_zero) begin
        w_drain_start = 1'b1;
      end else if (w_elig[r_ptr]) begin
        w_has_win = 1'b1;
        w_win     = r_ptr;
      end else if (w_elig[~r_ptr]) begin
        w_has_win = 1'b1;
        w_win     = ~r_ptr;
      end
    end
  end

  assign w_sel_op    = w_win ? bus.req_op[7:4]      : bus.req_op[3:0];
  assign w_sel_addr  = w_win ? bus.req_addr[63:32]  : bus.req_addr[31:0];
  assign w_sel_data  = w_win ? bus.req_data[127:64] : bus.req_data[63:0];
  assign w_sel_wmask = w_win ? bus.req_wmask[15:8]  : bus.req_wmask[7:0];
  assign w_sel_tag   = w_win ? bus.req_tag[23:12]   : bus.req_tag[11:0];

  assign bus.mem_req_val   = w_has_win;
  assign bus.mem_req_op    = r_lock_val ? r_lock_op    : w_sel_op;
  assign bus.mem_req_addr  = r_lock_val ? r_lock_addr  : w_sel_addr;
  assign bus.mem_req_data  = r_lock_val ? r_lock_data  : w_sel_data;
  assign bus.mem_req_wmask = r_lock_val ? r_lock_wmask : w_sel_wmask;
  assign bus.mem_req_tag   = {w_win, (r_lock_val ? r_lock_tag : w_sel_tag)};

  assign bus.req_rdy   = w_hs ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_val  = bus.mem_resp_val ? (bus.mem_resp_tag[12] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_tag  = bus.mem_resp_tag[11:0];
  assign bus.resp_data = bus.mem_resp_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ARB;
      r_ptr        <= 1'b0;
      r_owner      <= 1'b0;
      r_owner_go   <= 1'b0;
      r_lock_val   <= 1'b0;
      r_lock_idx   <= 1'b0;
      r_lock_op    <= 4'd0;
      r_lock_addr  <= 32'd0;
      r_lock_data  <= 64'd0;
      r_lock_wmask <= 8'd0;
      r_lock_tag   <= 12'd0;
    end else begin
      if (w_hs) begin
        r_ptr <= ~w_win;
      end
      r_owner_go <= 1'b0;
      case (r_state)
        ST_ARB: begin
          if (w_drain_start) begin
            r_state <= ST_DRAIN;
            r_owner <= w_top_idx;
          end
        end
        ST_DRAIN: begin
          // The flush owner gets one guaranteed grant once everything has drained.
          if (w_total_zero) begin
            r_state    <= ST_ARB;
            r_owner_go <= 1'b1;
          end
        end
        default: r_state <= ST_ARB;
      endcase
      if (w_hs) begin
        r_lock_val <= 1'b0;
      end else if (w_has_win && !r_lock_val) begin
        r_lock_val   <= 1'b1;
        r_lock_idx   <= w_win;
        r_lock_op    <= w_sel_op;
        r_lock_addr  <= w_sel_addr;
        r_lock_data  <= w_sel_data;
        r_lock_wmask <= w_sel_wmask;
        r_lock_tag   <= w_sel_tag;
      end
    end
  end
endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed self-checking bench for riscv_dmem_arbiter: round-robin, outstanding
// limit, flush drain, backpressure hold, response steering and async reset.
module tb_riscv_dmem_arbiter;
  localparam logic [3:0] M_XRD = 4'b0000;
  localparam logic [3:0] M_FLA = 4'b0100;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  riscv_dmem_arbiter_if bus();

  riscv_dmem_arbiter #(.MAX_OUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench did not finish");
  end

  task automatic idle_inputs();
    bus.req_val       = 2'b00;
    bus.req_op        = 8'h00;
    bus.req_addr      = 64'h0;
    bus.req_data      = 128'h0;
    bus.req_wmask     = 16'h0;
    bus.req_tag       = 24'h0;
    bus.mem_req_rdy   = 1'b0;
    bus.mem_resp_val  = 1'b0;
    bus.mem_resp_tag  = 13'h0;
    bus.mem_resp_data = 64'h0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] addr, input logic [63:0] data,
                         input logic [11:0] tag);
    bus.req_val[i]          = v;
    bus.req_op[i*4 +: 4]    = op;
    bus.req_addr[i*32 +: 32] = addr;
    bus.req_data[i*64 +: 64] = data;
    bus.req_wmask[i*8 +: 8] = 8'hFF;
    bus.req_tag[i*12 +: 12] = tag;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    checks++; if (bus.mem_req_val !== 1'b0) begin errors++; $display("FAIL reset_memval: got %b want 0", bus.mem_req_val); end
    checks++; if (bus.req_rdy !== 2'b00) begin errors++; $display("FAIL reset_reqrdy: got %b want 00", bus.req_rdy); end
    checks++; if (bus.resp_val !== 2'b00) begin errors++; $display("FAIL reset_respval: got %b want 00", bus.resp_val); end
    $display("test_reset: outputs idle with reset held and no clock edge");
  endtask

  task automatic test_round_robin();
    logic       exp_w;
    logic       prev_w;
    logic [11:0] prev_t;
    do_reset();
    bus.mem_req_rdy = 1'b1;
    set_req(0, 1'b1, M_XRD, 32'h0000_1000, 64'hA0, 12'h100);
    set_req(1, 1'b1, M_XRD, 32'h0000_2000, 64'hB0, 12'h200);
    prev_w = 1'b0;
    prev_t = 12'h0;
    for (int k = 0; k < 5; k++) begin
      exp_w = (k % 2) != 0;
      if (k > 0) begin
        bus.mem_resp_val = 1'b1;
        bus.mem_resp_tag = {prev_w, prev_t};
      end
      if (k == 4) bus.req_val = 2'b00;
      #2;
      if (k < 4) begin
        checks++; if (bus.mem_req_val !== 1'b1) begin errors++; $display("FAIL rr_val%0d: got %b want 1", k, bus.mem_req_val); end
        checks++; if (bus.mem_req_tag[12] !== exp_w) begin errors++; $display("FAIL rr_win%0d: got %b want %b", k, bus.mem_req_tag[12], exp_w); end
        checks++; if (bus.req_rdy !== (exp_w ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_rdy%0d: got %b want %b", k, bus.req_rdy, exp_w ? 2'b10 : 2'b01); end
        checks++; if (bus.mem_req_addr !== (exp_w ? 32'h2000 : 32'h1000)) begin errors++; $display("FAIL rr_addr%0d: got %h want %h", k, bus.mem_req_addr, exp_w ? 32'h2000 : 32'h1000); end
        $display("test_round_robin: grant %0d to requester %0d", k, exp_w);
      end
      if (k > 0) begin
        checks++; if (bus.resp_val !== (prev_w ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_resp%0d: got %b want %b", k, bus.resp_val, prev_w ? 2'b10 : 2'b01); end
      end
      prev_w = exp_w;
      prev_t = exp_w ? 12'h200 : 12'h100;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_max_out();
    do_reset();
    bus.mem_req_rdy  = 1'b1;
    bus.mem_resp_val = 1'b1;
    bus.mem_resp_tag = 13'h0_000;
    next_cycle();
    bus.mem_resp_val = 1'b0;
    set_req(0, 1'b1, M_XRD, 32'h0000_8000, 64'h1, 12'h010);
    for (int k = 0; k < 4; k++) begin
      #2;
      checks++; if (bus.req_rdy !== 2'b01) begin errors++; $display("FAIL max_load%0d: got %b want 01", k, bus.req_rdy); end
      $display("test_max_out: load %0d accepted", k);
      next_cycle();
    end
    #2;
    checks++; if (bus.req_rdy !== 2'b00) begin errors++; $display("FAIL max_block_rdy: got %b want 00", bus.req_rdy); end
    checks++; if (bus.mem_req_val !== 1'b0) begin errors++; $display("FAIL max_block_val: got %b want 0", bus.mem_req_val); end
    bus.mem_resp_val = 1'b1;
    bus.mem_resp_tag = 13'h0_000;
    #1;
    checks++; if (bus.req_rdy !== 2'b00) begin errors++; $display("FAIL max_same_cycle: got %b want 00", bus.req_rdy); end
    next_cycle();
    bus.mem_resp_val = 1'b0;
    #2;
    checks++; if (bus.req_rdy !== 2'b01) begin errors++; $display("FAIL max_resume: got %b want 01", bus.req_rdy); end
    $display("test_max_out: fifth load accepted after one response");
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_drain();
    do_reset();
    bus.mem_req_rdy = 1'b1;
    set_req(0, 1'b1, M_XRD, 32'h0000_1100, 64'h2, 12'h011);
    for (int k = 0; k < 2; k++) begin
      #2;
      checks++; if (bus.req_rdy !== 2'b01) begin errors++; $display("FAIL drain_pre%0d: got %b want 01", k, bus.req_rdy); end
      next_cycle();
    end
    set_req(1, 1'b1, M_FLA, 32'h0000_3000, 64'h0, 12'h0F0);
    #2;
    checks++; if (bus.mem_req_val !== 1'b0) begin errors++; $display("FAIL drain_entry_val: got %b want 0", bus.mem_req_val); end
    checks++; if (bus.req_rdy !== 2'b00) begin errors++; $display("FAIL drain_entry_rdy: got %b want 00", bus.req_rdy); end
    next_cycle();
    #2;
    checks++; if (bus.mem_req_val !== 1'b0) begin errors++; $display("FAIL drain_hold: got %b want 0", bus.mem_req_val); end
    next_cycle();
    for (int r = 0; r < 2; r++) begin
      bus.mem_resp_val = 1'b1;
      bus.mem_resp_tag = {1'b0, 12'h011};
      #2;
      checks++; if (bus.mem_req_val !== 1'b0) begin errors++; $display("FAIL drain_resp_val%0d: got %b want 0", r, bus.mem_req_val); end
      checks++; if (bus.resp_val !== 2'b01) begin errors++; $display("FAIL drain_resp_steer%0d: got %b want 01", r, bus.resp_val); end
      $display("test_drain: response %0d returned to requester 0", r);
      next_cycle();
    end
    bus.mem_resp_val = 1'b0;
    #2;
    checks++; if (bus.mem_req_val !== 1'b0) begin errors++; $display("FAIL drain_zero_cycle: got %b want 0", bus.mem_req_val); end
    next_cycle();
    #2;
    checks++; if (bus.mem_req_val !== 1'b1) begin errors++; $display("FAIL drain_flush_val: got %b want 1", bus.mem_req_val); end
    checks++; if (bus.mem_req_tag !== {1'b1, 12'h0F0}) begin errors++; $display("FAIL drain_flush_tag: got %h want %h", bus.mem_req_tag, {1'b1, 12'h0F0}); end
    checks++; if (bus.mem_req_op !== M_FLA) begin errors++; $display("FAIL drain_flush_op: got %h want %h", bus.mem_req_op, M_FLA); end
    checks++; if (bus.req_rdy !== 2'b10) begin errors++; $display("FAIL drain_flush_rdy: got %b want 10", bus.req_rdy); end
    $display("test_drain: flush issued for requester 1");
    next_cycle();
    set_req(1, 1'b0, M_XRD, 32'h0, 64'h0, 12'h0);
    #2;
    checks++; if (bus.req_rdy !== 2'b01) begin errors++; $display("FAIL drain_after: got %b want 01", bus.req_rdy); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.mem_req_rdy = 1'b1;
    set_req(0, 1'b1, M_XRD, 32'h0000_0100, 64'h11, 12'h001);
    #2;
    checks++; if (bus.req_rdy !== 2'b01) begin errors++; $display("FAIL bp_warm: got %b want 01", bus.req_rdy); end
    next_cycle();
    bus.mem_req_rdy = 1'b0;
    set_req(0, 1'b1, M_XRD, 32'h0000_4440, 64'hCAFE, 12'h044);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_req(1, 1'b1, M_XRD, 32'h0000_5550, 64'hBEEF, 12'h055);
      #2;
      checks++; if (bus.mem_req_val !== 1'b1) begin errors++; $display("FAIL bp_val%0d: got %b want 1", k, bus.mem_req_val); end
      checks++; if (bus.mem_req_tag !== {1'b0, 12'h044}) begin errors++; $display("FAIL bp_tag%0d: got %h want %h", k, bus.mem_req_tag, {1'b0, 12'h044}); end
      checks++; if (bus.mem_req_addr !== 32'h0000_4440) begin errors++; $display("FAIL bp_addr%0d: got %h want 00004440", k, bus.mem_req_addr); end
      checks++; if (bus.mem_req_data !== 64'hCAFE) begin errors++; $display("FAIL bp_data%0d: got %h want cafe", k, bus.mem_req_data); end
      checks++; if (bus.req_rdy !== 2'b00) begin errors++; $display("FAIL bp_rdy%0d: got %b want 00", k, bus.req_rdy); end
      $display("test_back_to_back: stall cycle %0d holds requester 0", k);
      next_cycle();
    end
    bus.mem_req_rdy = 1'b1;
    #2;
    checks++; if (bus.req_rdy !== 2'b01) begin errors++; $display("FAIL bp_accept: got %b want 01", bus.req_rdy); end
    next_cycle();
    set_req(0, 1'b0, M_XRD, 32'h0, 64'h0, 12'h0);
    #2;
    checks++; if (bus.mem_req_tag !== {1'b1, 12'h055}) begin errors++; $display("FAIL bp_next_tag: got %h want %h", bus.mem_req_tag, {1'b1, 12'h055}); end
    checks++; if (bus.req_rdy !== 2'b10) begin errors++; $display("FAIL bp_next_rdy: got %b want 10", bus.req_rdy); end
    checks++; if (bus.mem_req_addr !== 32'h0000_5550) begin errors++; $display("FAIL bp_next_addr: got %h want 00005550", bus.mem_req_addr); end
    $display("test_back_to_back: requester 1 granted after release");
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_resp_steer();
    do_reset();
    bus.mem_req_rdy = 1'b1;
    set_req(1, 1'b1, M_XRD, 32'h0000_6000, 64'h5, 12'h0A5);
    #2;
    checks++; if (bus.req_rdy !== 2'b10) begin errors++; $display("FAIL steer_grant: got %b want 10", bus.req_rdy); end
    next_cycle();
    set_req(1, 1'b0, M_XRD, 32'h0, 64'h0, 12'h0);
    bus.mem_resp_val  = 1'b1;
    bus.mem_resp_tag  = 13'h1_0A5;
    bus.mem_resp_data = 64'h0123_4567_89AB_CDEF;
    #2;
    checks++; if (bus.resp_val !== 2'b10) begin errors++; $display("FAIL steer_val: got %b want 10", bus.resp_val); end
    checks++; if (bus.resp_tag !== 12'h0A5) begin errors++; $display("FAIL steer_tag: got %h want 0a5", bus.resp_tag); end
    checks++; if (bus.resp_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL steer_data: got %h want 0123456789abcdef", bus.resp_data); end
    $display("test_resp_steer: response tag 10a5 steered to requester 1");
    next_cycle();
    bus.mem_resp_val = 1'b0;
    set_req(1, 1'b1, M_FLA, 32'h0000_7000, 64'h0, 12'h0AA);
    #2;
    checks++; if (bus.mem_req_val !== 1'b1) begin errors++; $display("FAIL steer_flush_val: got %b want 1", bus.mem_req_val); end
    checks++; if (bus.req_rdy !== 2'b10) begin errors++; $display("FAIL steer_flush_rdy: got %b want 10", bus.req_rdy); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.mem_req_rdy = 1'b1;
    set_req(0, 1'b1, M_XRD, 32'h0000_9000, 64'h9, 12'h090);
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (bus.req_rdy !== 2'b01) begin errors++; $display("FAIL rmid_pre%0d: got %b want 01", k, bus.req_rdy); end
      next_cycle();
    end
    set_req(1, 1'b1, M_FLA, 32'h0000_A000, 64'h0, 12'h0A0);
    #2;
    checks++; if (bus.mem_req_val !== 1'b0) begin errors++; $display("FAIL rmid_drain_entry: got %b want 0", bus.mem_req_val); end
    next_cycle();
    #2;
    checks++; if (bus.mem_req_val !== 1'b0) begin errors++; $display("FAIL rmid_drain: got %b want 0", bus.mem_req_val); end
    bus.req_val = 2'b00;
    reset = 1'b0;
    #1;
    checks++; if (bus.mem_req_val !== 1'b0) begin errors++; $display("FAIL rmid_async_val: got %b want 0", bus.mem_req_val); end
    checks++; if (bus.req_rdy !== 2'b00) begin errors++; $display("FAIL rmid_async_rdy: got %b want 00", bus.req_rdy); end
    checks++; if (bus.resp_val !== 2'b00) begin errors++; $display("FAIL rmid_async_resp: got %b want 00", bus.resp_val); end
    next_cycle();
    reset = 1'b1;
    set_req(0, 1'b1, M_XRD, 32'h0000_B000, 64'hB, 12'h0B0);
    set_req(1, 1'b1, M_XRD, 32'h0000_C000, 64'hC, 12'h0C0);
    #2;
    checks++; if (bus.mem_req_val !== 1'b1) begin errors++; $display("FAIL rmid_arb_val: got %b want 1", bus.mem_req_val); end
    checks++; if (bus.mem_req_tag[12] !== 1'b0) begin errors++; $display("FAIL rmid_ptr: got %b want 0", bus.mem_req_tag[12]); end
    checks++; if (bus.req_rdy !== 2'b01) begin errors++; $display("FAIL rmid_rdy: got %b want 01", bus.req_rdy); end
    $display("test_reset_mid: requester 0 granted after reset release");
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_max_out();
    test_drain();
    test_back_to_back();
    test_resp_steer();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_dmem_arbiter.md
RISCV_DMEM_ARBITER -- requirements
Module: riscv_dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4: the maximum number of unacknowledged requests per requester (range 1..15).
REQ-002 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req_val, input, 2: per-requester request valid; bit i belongs to requester i.
REQ-005 SHALL have port req_rdy, output, 2: per-requester accept.
REQ-006 SHALL have port req_op, input, 8: {op1,op0}, each 4 bits, M_* encoding.
REQ-007 SHALL have port req_addr, input, 64: {addr1,addr0}, each 32 bits, doubleword aligned.
REQ-008 SHALL have port req_data, input, 128: {data1,data0}, each 64 bits.
REQ-009 SHALL have port req_wmask, input, 16: {wmask1,wmask0}, each 8 bits.
REQ-010 SHALL have port req_tag, input, 24: {tag1,tag0}, each 12 bits.
REQ-011 SHALL have port mem_req_val, output, 1: request to the data memory.
REQ-012 SHALL have port mem_req_rdy, input, 1: the data memory accepts the request.
REQ-013 SHALL have ports mem_req_op (output, 4), mem_req_addr (output, 32), mem_req_data (output, 64) and mem_req_wmask (output, 8): the selected requester's fields.
REQ-014 SHALL have port mem_req_tag, output, 13: {winner index, winner tag}.
REQ-015 SHALL have port mem_resp_val, input, 1: memory response valid.
REQ-016 SHALL have ports mem_resp_tag (input, 13) and mem_resp_data (input, 64): response tag and data.
REQ-017 SHALL have port resp_val, output, 2: response valid, steered to one requester.
REQ-018 SHALL have ports resp_tag (output, 12) and resp_data (output, 64): mem_resp_tag[11:0] and mem_resp_data, passed through combinationally.

Function
REQ-019 SHALL count accepted requests per requester in cnt[i], width 4.
- cnt[i] increments on a handshake for requester i.
- cnt[i] decrements on mem_resp_val with mem_resp_tag[12]==i.
- Simultaneous increment and decrement leave cnt[i] unchanged.
- A decrement when cnt[i]==0 leaves it at 0.
REQ-020 SHALL treat requester i as eligible when req_val[i] & cnt[i]<MAX_OUT & (op_i != M_FLA | cnt[0]+cnt[1]==0).
REQ-021 SHALL choose the winner by round-robin.
- Pointer ptr (1 bit) selects the preferred requester: the preferred one wins if eligible, otherwise the other wins if eligible.
- On every handshake (mem_req_val & mem_req_rdy), ptr becomes the inverse of the accepted index.
REQ-022 SHALL hold the winner stable under backpressure.
- When mem_req_val=1 and mem_req_rdy=0, the winner and all mem_req_* fields are held (lock register) until the handshake.
- Requester i SHALL NOT drop req_val[i] before its handshake.
REQ-023 SHALL drive mem_req_val = (a winner exists), independent of mem_req_rdy.
REQ-024 SHALL drive req_rdy[i] = mem_req_rdy & mem_req_val & (winner==i); req_rdy to the other requester is 0.
REQ-025 SHALL implement the FSM ARB/DRAIN.
- ARB: if the highest-priority valid requester presents M_FLA while cnt[0]+cnt[1]!=0, go to DRAIN with that requester latched as owner; no grant is given that cycle.
- DRAIN: no grants to either requester; mem_req_val=0.
- DRAIN to ARB: the cycle after the registered total reaches 0; the owner then wins unconditionally in ARB for that cycle.
REQ-026 SHALL issue a flush with zero latency when the total count is already 0 (no DRAIN).
REQ-027 SHALL drive resp_val[i] = mem_resp_val & (mem_resp_tag[12]==i), combinationally with zero latency.
REQ-028 SHALL count every accepted request (loads, stores, AMOs, flushes) as exactly one response.

Reset
REQ-029 SHALL on reset=0, immediately and asynchronously, set cnt[0]=cnt[1]=0, ptr=0, FSM=ARB and lock cleared, giving mem_req_val=0, req_rdy=0 and resp_val=0 while no inputs are valid.
REQ-030 SHALL lose all in-flight bookkeeping on reset mid-operation; responses for those requests arriving after reset are clamped per REQ-019.

Verification
REQ-031 SHALL cover: both req_val=1 with op=M_XRD, mem_req_rdy=1, responses returned 1 cycle later -> mem_req_tag[12] sequence 0,1,0,1; resp_val alternates 01,10.
REQ-032 SHALL cover: MAX_OUT=4, r0 issues 4 loads with no responses, r1 idle -> 5th r0 request sees req_rdy[0]=0; response with tag 13'h0_000 -> r0 granted the next cycle.
REQ-033 SHALL cover: cnt0=2, r1 presents M_FLA -> DRAIN, mem_req_val=0 while r0 stays valid; two responses -> flush issued the cycle after cnt0 reaches 0, mem_req_tag[12]=1.
REQ-034 SHALL cover: mem_req_rdy=0 for 3 cycles with r0 winning and r1 raising req_val -> winner stays r0 and all fields are stable; after the accept, r1 is granted.
REQ-035 SHALL cover: mem_resp_tag=13'h1_0A5 -> resp_val=2'b10, resp_tag=12'h0A5, cnt1 decremented.
REQ-036 SHALL cover: reset asserted in DRAIN with cnt0=3 -> outputs 0 without a clock edge; after release FSM=ARB and ptr=0.
